// File: rtl/mux_sel_arb_pkg.sv
// rtl/mux_sel_arb_pkg.sv - shared mode constants and width helper for mux_sel_arb
package mux_sel_arb_pkg;

   localparam int MUX_MODE_SEL = 0;
   localparam int MUX_MODE_PRI = 1;
   localparam int MUX_MODE_RR  = 2;

   // Index width for n channels, never below one bit.
   function automatic int mux_clog2(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/mux_sel_arb_rr_arbiter.sv
// rtl/mux_sel_arb_rr_arbiter.sv - rotating-priority arbiter; ROTATE=0 gives fixed priority
module rr_arbiter
   import mux_sel_arb_pkg::*;
#(
   parameter  int N      = 4,
   parameter  bit ROTATE = 1'b1,
   localparam int SELW   = mux_clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            adv,
   output logic [N-1:0]    gnt,
   output logic [SELW-1:0] gnt_idx
);

   logic [SELW-1:0] ptr_q;
   logic [SELW-1:0] ptr_d;
   logic            found;
   int              j;

   // Search starts at the pointer and wraps so every requester is reached.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_q) + k;
         if (j >= N) j = j - N;
         if (!found && req[j]) begin
            found   = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = SELW'(j);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (ROTATE && adv) begin
         ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mux_sel_arb.sv
// rtl/mux_sel_arb.sv - N-input registered selector with valid/ready on every channel
module mux_sel_arb
   import mux_sel_arb_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int N     = 4,
   parameter  int MODE  = 0,
   localparam int SELW  = mux_clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]       in_valid,
   output logic [N-1:0]       in_ready,
   input  logic [SELW-1:0]    sel,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SELW-1:0]    out_src
);

   generate
      if (N < 2 || N > 16 || MODE < 0 || MODE > 2) begin : g_bad_param
         $error("mux_sel_arb: illegal N or MODE");
      end
   endgenerate

   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic [SELW-1:0]  out_src_q, out_src_d;
   logic [N-1:0]     g, arb_gnt;
   logic [SELW-1:0]  arb_idx, g_idx;
   logic [WIDTH-1:0] mux_word;
   logic             load, xfer;

   rr_arbiter #(
      .N      (N),
      .ROTATE (MODE == MUX_MODE_RR)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (in_valid),
      .adv     (xfer),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   // An out-of-range sel must never grant, so it is range-checked before indexing.
   always_comb begin
      g     = '0;
      g_idx = arb_idx;
      if (MODE == MUX_MODE_SEL) begin
         g_idx = sel;
         if (int'(sel) < N) g[sel] = in_valid[sel];
      end else begin
         g = arb_gnt;
      end
   end

   assign load     = !out_valid_q || out_ready;
   assign in_ready = (load && !rst) ? g : '0;
   assign xfer     = |(in_valid & in_ready);

   always_comb begin
      mux_word = '0;
      for (int i = 0; i < N; i++) begin
         if (g[i]) mux_word = in_data[i*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      out_valid_d = load ? xfer : out_valid_q;
      out_data_d  = xfer ? mux_word : out_data_q;
      out_src_d   = xfer ? g_idx : out_src_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;

endmodule
